// File: rtl/dc_banked_data_array.sv
// dc_banked_data_array
//   Multi-bank L1 data-cache data array. Each bank holds WAYS x 2^INDEX_W
//   entries of {data, byte-valid mask}. A load-read channel and a
//   store-write channel can both be served in one cycle when they target
//   different banks. A same-bank collision is settled by a toggling priority
//   bit. An invalidate clears one index/way in every bank and stalls both
//   request channels for that cycle. Load results go through a one-stage
//   read register and a 2-entry output FIFO that supports back-pressure.
//
// Ports
//   clk, reset (async, active-low)
//   ld_req_{valid,retry,bank,index,way}             load request channel
//   st_req_{valid,retry,bank,index,way,data,bmask}  store request channel
//   inv_{valid,index,way}                            invalidate (always accepted)
//   ld_ack_{valid,retry,data,vmask}                  load result channel
module dc_banked_data_array #(
  parameter int unsigned NBANKS  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned INDEX_W = 5,
  parameter int unsigned WAYS    = 8,
  localparam int unsigned BANK_W = $clog2(NBANKS),
  localparam int unsigned WAY_W  = $clog2(WAYS),
  localparam int unsigned VM_W   = DATA_W / 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld_req_valid,
  output logic               ld_req_retry,
  input  logic [BANK_W-1:0]  ld_req_bank,
  input  logic [INDEX_W-1:0] ld_req_index,
  input  logic [WAY_W-1:0]   ld_req_way,
  input  logic               st_req_valid,
  output logic               st_req_retry,
  input  logic [BANK_W-1:0]  st_req_bank,
  input  logic [INDEX_W-1:0] st_req_index,
  input  logic [WAY_W-1:0]   st_req_way,
  input  logic [DATA_W-1:0]  st_req_data,
  input  logic [VM_W-1:0]    st_req_bmask,
  input  logic               inv_valid,
  input  logic [INDEX_W-1:0] inv_index,
  input  logic [WAY_W-1:0]   inv_way,
  output logic               ld_ack_valid,
  input  logic               ld_ack_retry,
  output logic [DATA_W-1:0]  ld_ack_data,
  output logic [VM_W-1:0]    ld_ack_vmask
);

  localparam int unsigned ADDR_W  = WAY_W + INDEX_W;
  localparam int unsigned ENTRIES = 1 << ADDR_W;

  logic [DATA_W-1:0] data_mem  [NBANKS][ENTRIES];
  logic [VM_W-1:0]   vmask_mem [NBANKS][ENTRIES];

  logic [ADDR_W-1:0] ld_addr, st_addr, inv_addr;
  assign ld_addr  = {ld_req_way, ld_req_index};
  assign st_addr  = {st_req_way, st_req_index};
  assign inv_addr = {inv_way, inv_index};

  logic              rr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [VM_W-1:0]   rd_vmask;
  logic [DATA_W-1:0] fifo_data  [2];
  logic [VM_W-1:0]   fifo_vmask [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt;

  logic credit_full, conflict, ld_fire, st_fire, pop, pop_fifo, push;

  // A collision is only arbitrated when the load could otherwise be accepted;
  // a credit-stalled load does not block the store or consume a toggle.
  always_comb begin
    credit_full  = (fifo_cnt + {1'b0, rd_valid}) == 2'd2;
    conflict     = ld_req_valid && st_req_valid && !inv_valid && !credit_full &&
                   (ld_req_bank == st_req_bank);
    ld_req_retry = inv_valid || credit_full || (conflict && rr);
    st_req_retry = inv_valid || (conflict && !rr);
    ld_fire      = ld_req_valid && !ld_req_retry;
    st_fire      = st_req_valid && !st_req_retry;
  end

  // The read register is the youngest element of the visible queue: when the
  // FIFO is empty it drives the ack directly, giving one-cycle load latency.
  always_comb begin
    ld_ack_valid = (fifo_cnt != 2'd0) || rd_valid;
    ld_ack_data  = (fifo_cnt != 2'd0) ? fifo_data[rd_ptr]  : rd_data;
    ld_ack_vmask = (fifo_cnt != 2'd0) ? fifo_vmask[rd_ptr] : rd_vmask;
    pop          = ld_ack_valid && !ld_ack_retry;
    pop_fifo     = pop && (fifo_cnt != 2'd0);
    push         = rd_valid && !(pop && (fifo_cnt == 2'd0));
  end

  always_ff @(posedge clk) begin
    if (st_fire) begin
      for (int unsigned b = 0; b < VM_W; b++) begin
        if (st_req_bmask[b]) data_mem[st_req_bank][st_addr][8*b +: 8] <= st_req_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned b = 0; b < NBANKS; b++) begin
        for (int unsigned e = 0; e < ENTRIES; e++) vmask_mem[b][e] <= '0;
      end
    end else if (inv_valid) begin
      for (int unsigned b = 0; b < NBANKS; b++) vmask_mem[b][inv_addr] <= '0;
    end else if (st_fire) begin
      vmask_mem[st_req_bank][st_addr] <= vmask_mem[st_req_bank][st_addr] | st_req_bmask;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr            <= 1'b0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      rd_vmask      <= '0;
      fifo_data[0]  <= '0;
      fifo_data[1]  <= '0;
      fifo_vmask[0] <= '0;
      fifo_vmask[1] <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      fifo_cnt      <= 2'd0;
    end else begin
      if (conflict) rr <= !rr;
      rd_valid <= ld_fire;
      if (ld_fire) begin
        rd_data  <= data_mem[ld_req_bank][ld_addr];
        rd_vmask <= vmask_mem[ld_req_bank][ld_addr];
      end
      if (push) begin
        fifo_data[wr_ptr]  <= rd_data;
        fifo_vmask[wr_ptr] <= rd_vmask;
        wr_ptr             <= !wr_ptr;
      end
      if (pop_fifo) rd_ptr <= !rd_ptr;
      unique case ({push, pop_fifo})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
